div_secuencial: RTL and testbench

DIV_SECUENCIAL -- requirements
Module: div_secuencial

---
 rtl/div_secuencial.sv | 113 +++++++++++
 tb/tb_div_secuencial.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/div_secuencial.sv
`default_nettype none
// ============================================================================
// div_secuencial : sequential restoring divider, one quotient bit per clock
// Revision: 1.0
// ============================================================================
module div_secuencial #(
  parameter int WN = 8,
  parameter int WD = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid,
  input  logic [WN-1:0] N,
  input  logic [WD-1:0] D,
  output logic [WN-1:0] quot,
  output logic [WD-1:0] rem,
  output logic          busy,
  output logic          DONE,
  output logic          div_zero
);

  localparam int c_CW = $clog2(WN + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [WN-1:0]   r_n;
  logic [WD-1:0]   r_d;
  logic [WD:0]     r_r;
  logic [WN-1:0]   r_q;
  logic [c_CW-1:0] r_cnt;

  logic [WD:0]     w_t;
  logic            w_ge;
  logic [WD:0]     w_r_nxt;
  logic [WN-1:0]   w_q_nxt;
  logic            w_last;

  // Partial remainder stays below D, so shifting out its top bit loses nothing.
  assign w_t     = (r_r << 1) | (WD + 1)'(r_n[WN-1]);
  assign w_ge    = (w_t >= {1'b0, r_d});
  assign w_r_nxt = w_ge ? (w_t - {1'b0, r_d}) : w_t;
  assign w_q_nxt = (r_q << 1) | WN'(w_ge);
  assign w_last  = (r_cnt == c_CW'(WN - 1));

  assign busy = (r_state != S_IDLE);
  assign DONE = (r_state == S_FIN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (valid) w_next = (D != '0) ? S_CALC : S_FIN;
      S_CALC:  if (w_last) w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_n      <= '0;
      r_d      <= '0;
      r_r      <= '0;
      r_q      <= '0;
      r_cnt    <= '0;
      quot     <= '0;
      rem      <= '0;
      div_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (valid) begin
            r_n   <= N;
            r_d   <= D;
            r_r   <= '0;
            r_q   <= '0;
            r_cnt <= '0;
            // Divide-by-zero skips CALC; its result is published on the same edge.
            if (D == '0) begin
              quot     <= '1;
              rem      <= N[WD-1:0];
              div_zero <= 1'b1;
            end
          end
        end
        S_CALC: begin
          r_r   <= w_r_nxt;
          r_q   <= w_q_nxt;
          r_n   <= r_n << 1;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            quot     <= w_q_nxt;
            rem      <= w_r_nxt[WD-1:0];
            div_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_secuencial.sv
`default_nettype none
// ============================================================================
// tb_div_secuencial : directed scoreboard bench for div_secuencial
// Revision: 1.0
// ============================================================================
module tb_div_secuencial;

  localparam int WN = 8;
  localparam int WD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid;
  logic [WN-1:0] N;
  logic [WD-1:0] D;
  logic [WN-1:0] quot;
  logic [WD-1:0] rem;
  logic          busy;
  logic          DONE;
  logic          div_zero;

  div_secuencial #(.WN(WN), .WD(WD)) dut (
    .clk(clk), .rst(rst), .valid(valid), .N(N), .D(D),
    .quot(quot), .rem(rem), .busy(busy), .DONE(DONE), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WN-1:0] n;
    logic [WD-1:0] d;
    logic [WN-1:0] q;
    logic [WD-1:0] r;
    logic          dz;
    int            acc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   edge_cnt = 0;

  always @(posedge clk) edge_cnt = edge_cnt + 1;

  task automatic check(input string name, input int got, input int expv);
    n_cmp++;
    if (got != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, got, expv, $time);
    end
  endtask

  // Monitor: every DONE pops one expected result; latency counts edges after the accepting edge.
  exp_t e;
  always @(negedge clk) begin
    if (rst === 1'b1 && DONE === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got DONE=1 quot=%0d rem=%0d required no DONE", quot, rem);
      end else begin
        e = sb.pop_front();
        check($sformatf("quot %0d/%0d", e.n, e.d), int'(quot), int'(e.q));
        check($sformatf("rem %0d/%0d", e.n, e.d), int'(rem), int'(e.r));
        check($sformatf("div_zero %0d/%0d", e.n, e.d), int'(div_zero), int'(e.dz));
        check($sformatf("busy_at_done %0d/%0d", e.n, e.d), int'(busy), 1);
        check($sformatf("latency %0d/%0d", e.n, e.d), edge_cnt - e.acc, (e.d == 0) ? 0 : WN);
      end
    end
  end

  // Issue one operation from IDLE; operand pins are scrambled afterwards to prove latching.
  task automatic start(input logic [WN-1:0] n, input logic [WD-1:0] d,
                       input logic [WN-1:0] q, input logic [WD-1:0] r,
                       input logic dz, input bit push);
    @(negedge clk);
    valid = 1'b1;
    N     = n;
    D     = d;
    @(posedge clk);
    #1;
    valid = 1'b0;
    N     = ~n;
    D     = ~d;
    if (push) sb.push_back('{n, d, q, r, dz, edge_cnt});
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (!busy && sb.size() == 0) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL timeout: got busy=%0d pending=%0d required idle with none pending", busy, sb.size());
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_quot"}, int'(quot), 0);
    check({tag, "_rem"}, int'(rem), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(DONE), 0);
    check({tag, "_div_zero"}, int'(div_zero), 0);
  endtask

  initial begin
    int a;
    rst   = 1'b0;
    valid = 1'b0;
    N     = '0;
    D     = '0;
    #12;
    check_zero("reset");

    // Release just after an edge so the very next edge is the accepting one.
    @(posedge clk);
    #2 rst = 1'b1;
    start(8'd49, 4'd7, 8'd7, 4'd0, 1'b0, 1'b1);
    wait_idle();
    start(8'd100, 4'd15, 8'd6, 4'd10, 1'b0, 1'b1);
    wait_idle();
    start(8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 1'b1);
    wait_idle();
    start(8'd3, 4'd9, 8'd0, 4'd3, 1'b0, 1'b1);
    wait_idle();
    start(8'd0, 4'd5, 8'd0, 4'd0, 1'b0, 1'b1);
    wait_idle();

    // New operands pulsed mid-CALC must be ignored.
    start(8'd100, 4'd15, 8'd6, 4'd10, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    valid = 1'b1;
    N     = 8'd255;
    D     = 4'd1;
    @(negedge clk);
    valid = 1'b0;
    wait_idle();
    repeat (12) @(negedge clk);

    start(8'd13, 4'd0, 8'hFF, 4'hD, 1'b1, 1'b1);
    wait_idle();

    // Abort at CALC iteration 4; outputs must clear before any clock edge.
    start(8'd49, 4'd7, 8'd7, 4'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1 check_zero("abort");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_idle_busy", int'(busy), 0);
    start(8'd49, 4'd7, 8'd7, 4'd0, 1'b0, 1'b1);
    wait_idle();

    // valid held high: second accept lands WN+2 edges after the first.
    @(negedge clk);
    valid = 1'b1;
    N     = 8'd200;
    D     = 4'd9;
    @(posedge clk);
    #1;
    a = edge_cnt;
    sb.push_back('{8'd200, 4'd9, 8'd22, 4'd2, 1'b0, a});
    sb.push_back('{8'd200, 4'd9, 8'd22, 4'd2, 1'b0, a + WN + 2});
    repeat (WN + 2) @(posedge clk);
    #1 valid = 1'b0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion required finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
